dmem_responder: RTL

- Memory-side responder for the core's data-memory request interface. The pipeline's MEM stage is the initiator; this block is the target.
- Accepts one load/store request at a time over a valid/ready handshake.
- Holds a word-addressed RAM and waits a programmable latency before responding.
- Returns formatted load data (byte/half/word, signed/unsigned) over a valid/ready response channel.
- Intended to replace the fixed single-cycle data memory once the core gains MEM-stage stall support.

---
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles, then returns formatted data.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned or illegal accesses through rsp_err.
module dmem_responder #(
  parameter int DATA_ADDRESS_WIDTH = 6,
  parameter int CPU_DATA_WIDTH     = 32,
  parameter int LATENCY            = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_funct3,
  input  logic [31:0]               req_addr,
  input  logic [CPU_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CPU_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err
);
  localparam int DEPTH = 2 ** DATA_ADDRESS_WIDTH;
  localparam int AW    = DATA_ADDRESS_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                      state_reg, state_next;
  logic [3:0]                  cnt_reg, cnt_next;
  logic                        wr_reg;
  logic [2:0]                  f3_reg;
  logic [AW-1:0]               addr_reg;
  logic [CPU_DATA_WIDTH-1:0]   wdata_reg;
  logic [CPU_DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                        err_reg, err_next;

  logic                        accept, commit, mem_we;
  logic                        legal, access_err, access_ok;
  logic [DATA_ADDRESS_WIDTH-1:0] rd_idx, wr_idx;
  logic [31:0]                 rd_word, shifted, load_data, store_data;
  logic [7:0]                  ld_byte;
  logic [15:0]                 ld_half;
  logic [3:0]                  store_be;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW];

  assign req_ready = (state_reg == IDLE) && !rst;
  assign rsp_valid = (state_reg == RESP) && !rst;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign accept    = req_valid && req_ready;
  assign commit    = (state_reg == WAIT) && (cnt_reg == 4'd0) && !rst;

  // Read address follows the live request in IDLE so the word is ready even when LATENCY is 1.
  assign rd_idx = (state_reg == IDLE) ? req_addr[AW-1:2] : addr_reg[AW-1:2];
  assign wr_idx = addr_reg[AW-1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_byte_reg;
      always_ff @(posedge clk) begin
        if (mem_we && store_be[gi])
          lane_mem[wr_idx] <= store_data[gi*8 +: 8];
        rd_byte_reg <= lane_mem[rd_idx];
      end
      assign rd_word[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

  always_comb begin
    shifted   = rd_word >> {addr_reg[1:0], 3'b000};
    ld_byte   = shifted[7:0];
    ld_half   = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    case (f3_reg)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = 32'd0;
    endcase
    legal = wr_reg ? (f3_reg inside {3'b000, 3'b001, 3'b010})
                   : (f3_reg inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DMEM_MISALIGN_ERR_EN
    access_err = !legal
               || ((f3_reg[1:0] == 2'b01) && addr_reg[0])
               || ((f3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
`else
    access_err = 1'b0;
`endif
    access_ok = legal && !access_err;
  end

  // Store data is replicated across lanes; the byte enables pick the target lane(s).
  always_comb begin
    store_be   = 4'b0000;
    store_data = wdata_reg;
    case (f3_reg[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr_reg[1:0];
        store_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        store_be   = addr_reg[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_reg[15:0]}};
      end
      2'b10:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign mem_we = commit && wr_reg && access_ok;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          rdata_next = (!wr_reg && access_ok) ? load_data : 32'd0;
          err_next   = access_err;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_reg    <= req_write;
      f3_reg    <= req_funct3;
      addr_reg  <= req_addr[AW-1:0];
      wdata_reg <= req_wdata;
    end
  end
endmodule
